// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter driving a SETUP/ACCESS (APB-style) transfer to one of two slaves.
// Define ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT not-ready cycles and flag err to the requester.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              req0,
    input  logic              wr0,
    input  logic              sel0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              done0,
    output logic              err0,
    input  logic              req1,
    input  logic              wr1,
    input  logic              sel1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done1,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata0,
    input  logic [DATA_W-1:0] prdata1,
    input  logic              pready0,
    input  logic              pready1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT must be at least 1");
    end

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic               gnt_q, gnt_d;
    logic               wr_q, wr_d;
    logic               sel_q, sel_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic               any_req;
    logic               grant_id;
    logic               sel_ready;
    logic [DATA_W-1:0]  sel_prdata;
    logic               timeout_hit;

    // Under contention the requester not granted last time wins; otherwise the lone requester wins.
    assign any_req    = req0 | req1;
    assign grant_id   = (req0 && req1) ? ~last_q : req1;
    assign sel_ready  = sel_q ? pready1 : pready0;
    assign sel_prdata = sel_q ? prdata1 : prdata0;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign timeout_hit = (state_q == ACCESS) && !sel_ready && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        case (state_q)
            SETUP: begin
                cnt_d = '0;
                err_d = 1'b0;
            end
            ACCESS: begin
                if (!sel_ready) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (timeout_hit) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err0 = (state_q == RESP) && !gnt_q && err_q;
    assign err1 = (state_q == RESP) &&  gnt_q && err_q;
`else
    assign timeout_hit = 1'b0;
    assign err0        = 1'b0;
    assign err1        = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            wr_q    <= 1'b0;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            wr_q    <= wr_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (sel_ready || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are captured once at grant so later requester activity cannot disturb the bus.
    always_comb begin
        last_d  = last_q;
        gnt_d   = gnt_q;
        wr_d    = wr_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (state_q == IDLE && any_req) begin
            gnt_d   = grant_id;
            last_d  = grant_id;
            wr_d    = grant_id ? wr1    : wr0;
            sel_d   = grant_id ? sel1   : sel0;
            addr_d  = grant_id ? addr1  : addr0;
            wdata_d = grant_id ? wdata1 : wdata0;
        end
        if (state_q == ACCESS && sel_ready && !wr_q) begin
            rdata_d = sel_prdata;
        end
    end

    always_comb begin
        psel    = 2'b00;
        penable = 1'b0;
        done0   = 1'b0;
        done1   = 1'b0;
        case (state_q)
            SETUP: begin
                psel = sel_q ? 2'b10 : 2'b01;
            end
            ACCESS: begin
                psel    = sel_q ? 2'b10 : 2'b01;
                penable = 1'b1;
            end
            RESP: begin
                done0 = !gnt_q;
                done1 = gnt_q;
            end
            default: ;
        endcase
    end

    assign pwrite = wr_q;
    assign paddr  = addr_q;
    assign pwdata = wdata_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: cycle-exact bus checks plus a completion scoreboard.
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clock;
    logic              reset;
    logic              req0, wr0, sel0, done0, err0;
    logic              req1, wr1, sel1, done1, err1;
    logic [ADDR_W-1:0] addr0, addr1, paddr;
    logic [DATA_W-1:0] wdata0, wdata1, rdata, pwdata, prdata0, prdata1;
    logic [1:0]        psel;
    logic              penable, pwrite, pready0, pready1;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic              id;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } expT;

    expT               sbQueue[$];
    expT               monEntry;
    logic [DATA_W-1:0] modelRdata;

    mem_bus_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(15)
    ) dut (
        .Clock  (clock),
        .Reset  (reset),
        .req0   (req0),
        .wr0    (wr0),
        .sel0   (sel0),
        .addr0  (addr0),
        .wdata0 (wdata0),
        .done0  (done0),
        .err0   (err0),
        .req1   (req1),
        .wr1    (wr1),
        .sel1   (sel1),
        .addr1  (addr1),
        .wdata1 (wdata1),
        .done1  (done1),
        .err1   (err1),
        .rdata  (rdata),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .prdata0(prdata0),
        .prdata1(prdata1),
        .pready0(pready0),
        .pready1(pready1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic tickCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic driveReq(input logic id, input logic r, input logic w, input logic s,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (!id) begin
            req0 = r; wr0 = w; sel0 = s; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; wr1 = w; sel1 = s; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic setSlaves(input logic s, input logic selReady, input logic [DATA_W-1:0] resp);
        if (!s) begin
            pready0 = selReady; prdata0 = resp;
            pready1 = 1'b1;     prdata1 = ~resp;
        end else begin
            pready1 = selReady; prdata1 = resp;
            pready0 = 1'b1;     prdata0 = ~resp;
        end
    endtask

    // One isolated transfer; request inputs are rewritten after SETUP to prove they were latched.
    task automatic applyStimulus(input logic id, input logic w, input logic s,
                                 input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                 input logic [DATA_W-1:0] resp, input int waits,
                                 input logic [ADDR_W-1:0] lateAddr);
        logic [1:0] expPsel;
        expPsel = s ? 2'b10 : 2'b01;
        driveReq(id, 1'b1, w, s, a, d);
        setSlaves(s, 1'b0, resp);
        if (!w) modelRdata = resp;
        sbQueue.push_back('{id: id, err: 1'b0, rdata: modelRdata});
        tickCycle();
        checkOutput("setup_psel", psel, expPsel);
        checkOutput("setup_penable", penable, 1'b0);
        checkOutput("setup_paddr", paddr, a);
        checkOutput("setup_pwrite", pwrite, w);
        checkOutput("setup_pwdata", pwdata, d);
        driveReq(id, 1'b1, ~w, ~s, lateAddr, ~d);
        for (int j = 0; j <= waits; j++) begin
            tickCycle();
            setSlaves(s, (j == waits), resp);
            checkOutput("access_psel", psel, expPsel);
            checkOutput("access_penable", penable, 1'b1);
            checkOutput("access_paddr", paddr, a);
            checkOutput("access_pwrite", pwrite, w);
            checkOutput("access_pwdata", pwdata, d);
            checkOutput("access_no_done", {done1, done0}, 2'b00);
        end
        tickCycle();
        checkOutput("resp_done", {done1, done0}, id ? 2'b10 : 2'b01);
        checkOutput("resp_psel", psel, 2'b00);
        checkOutput("resp_penable", penable, 1'b0);
        driveReq(id, 1'b0, 1'b0, 1'b0, '0, '0);
        tickCycle();
        checkOutput("idle_done", {done1, done0}, 2'b00);
        checkOutput("idle_psel", psel, 2'b00);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_psel"}, psel, 2'b00);
        checkOutput({tag, "_penable"}, penable, 1'b0);
        checkOutput({tag, "_pwrite"}, pwrite, 1'b0);
        checkOutput({tag, "_paddr"}, paddr, '0);
        checkOutput({tag, "_pwdata"}, pwdata, '0);
        checkOutput({tag, "_rdata"}, rdata, '0);
        checkOutput({tag, "_done"}, {done1, done0}, 2'b00);
        checkOutput({tag, "_err"}, {err1, err0}, 2'b00);
    endtask

    // Completion monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset) begin
            if (psel == 2'b11) checkOutput("psel_onehot", psel, 2'b01);
            if (done0 || done1) begin
                checkOutput("done_exclusive", done0 & done1, 1'b0);
                if (sbQueue.size() == 0) begin
                    checkOutput("sb_unexpected_done", 1'b1, 1'b0);
                end else begin
                    monEntry = sbQueue.pop_front();
                    checkOutput("sb_id", done1, monEntry.id);
                    checkOutput("sb_err", done1 ? err1 : err0, monEntry.err);
                    checkOutput("sb_rdata", rdata, monEntry.rdata);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        driveReq(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        driveReq(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        pready0 = 1'b0; pready1 = 1'b0; prdata0 = '0; prdata1 = '0;
        modelRdata = '0;
        #12;
        checkResetOutputs("reset");
        tickCycle();
        reset = 1'b0;
        tickCycle();

        $display("[TB] single read, slave 0, address rewritten during SETUP");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 0, 8'h99);
        $display("[TB] write to slave 1 with three wait states");
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h22, 32'h12345678, 32'hAAAA5555, 3, 8'h33);
        $display("[TB] read from slave 1 by requester 0, one wait state");
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h44, 32'h0, 32'hCAFEF00D, 1, 8'h45);
        $display("[TB] write to slave 0 by requester 0");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hF0, 32'h0BADF00D, 32'h55555555, 0, 8'h0F);

        $display("[TB] reset asserted during ACCESS");
        driveReq(1'b0, 1'b1, 1'b0, 1'b0, 8'h55, '0);
        setSlaves(1'b0, 1'b0, 32'h77777777);
        tickCycle();
        tickCycle();
        checkOutput("pre_reset_penable", penable, 1'b1);
        #2 reset = 1'b1;
        #1;
        checkResetOutputs("midreset");
        modelRdata = '0;
        driveReq(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        tickCycle();
        tickCycle();
        checkOutput("in_reset_done", {done1, done0}, 2'b00);
        reset = 1'b0;
        tickCycle();

        $display("[TB] full contention after reset");
        driveReq(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, '0);
        driveReq(1'b1, 1'b1, 1'b0, 1'b1, 8'h02, '0);
        pready0 = 1'b1; prdata0 = 32'h11110000;
        pready1 = 1'b1; prdata1 = 32'h22220000;
        for (int n = 0; n < 4; n++) begin
            modelRdata = (n % 2 == 0) ? 32'h11110000 : 32'h22220000;
            sbQueue.push_back('{id: logic'(n % 2), err: 1'b0, rdata: modelRdata});
        end
        for (int k = 1; k <= 16; k++) begin
            tickCycle();
            checkOutput("cont_done0", done0, (k % 8 == 3));
            checkOutput("cont_done1", done1, (k % 8 == 7));
            if (k % 4 == 1) checkOutput("cont_grant", psel, (k % 8 == 1) ? 2'b01 : 2'b10);
            if (k == 15) begin
                driveReq(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
                driveReq(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
            end
        end
        tickCycle();
        checkOutput("cont_idle_psel", psel, 2'b00);

        $display("[TB] selected slave never ready");
        driveReq(1'b0, 1'b1, 1'b0, 1'b0, 8'h77, '0);
        setSlaves(1'b0, 1'b0, 32'h99999999);
`ifdef ARB_TIMEOUT_EN
        sbQueue.push_back('{id: 1'b0, err: 1'b1, rdata: modelRdata});
        tickCycle();
        for (int j = 0; j < 15; j++) begin
            tickCycle();
            checkOutput("to_penable", penable, 1'b1);
            checkOutput("to_no_done", {done1, done0}, 2'b00);
        end
        tickCycle();
        checkOutput("to_done0", done0, 1'b1);
        checkOutput("to_err0", err0, 1'b1);
        checkOutput("to_rdata", rdata, modelRdata);
        driveReq(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        tickCycle();
        checkOutput("to_idle_psel", psel, 2'b00);
`else
        tickCycle();
        for (int j = 0; j < 100; j++) tickCycle();
        checkOutput("hang_penable", penable, 1'b1);
        checkOutput("hang_psel", psel, 2'b01);
        checkOutput("hang_done", {done1, done0}, 2'b00);
        driveReq(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        tickCycle();
        reset = 1'b0;
        tickCycle();
`endif

        checkOutput("sb_empty", sbQueue.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
